// File: rtl/pe_link_packer.sv
// -----------------------------------------------------------------------------
// pe_link_packer
//
// Stream-to-link transmitter for the 130-bit inter-PE north links. Lanes from a
// 32-bit valid/ready stream are packed, up to three per word, into a link word.
// Each word is driven onto out_to_north as a one-cycle valid pulse, and only in
// cycles where ap_start is high.
//
// Link word layout:
//   [129]     valid
//   [128]     last (frame end)
//   [127:98]  zero
//   [97:96]   lane count, 1..3
//   [95:0]    payload, lane0 at [31:0], lane1 at [63:32], lane2 at [95:64]
//             (unused lanes are zero)
//
// Ports:
//   clk           in   clock, all state changes on the rising edge
//   reset         in   asynchronous active-high reset
//   ap_start      in   link enable; a word is emitted only while high
//   din           in   stream lane data
//   din_valid     in   din is valid
//   din_last      in   final lane of a frame (qualified by din_valid)
//   din_ready     out  lane can be accepted this cycle (from pack_full only)
//   out_to_north  out  registered link word
//   busy          out  a lane or word is held in the pack or staged registers
//
// Storage is two words deep: the staged register feeds the output register,
// and the pack register collects lanes. A completed word that finds staged
// occupied waits in the pack register and blocks further input.
// -----------------------------------------------------------------------------
module pe_link_packer #(
    parameter int NORTH_WIDTH = 130,
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   din_valid,
    input  logic                   din_last,
    output logic                   din_ready,
    output logic [NORTH_WIDTH-1:0] out_to_north,
    output logic                   busy
);

    localparam int PAYLOAD_W = DATA_WIDTH * LANES;
    localparam int CNT_W     = 2;
    localparam int PAD_W     = NORTH_WIDTH - 2 - CNT_W - PAYLOAD_W;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LANES - 1);

    // ------------------------------------------------------------------
    // Pack register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_lane [LANES];
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pack_last;
    logic [CNT_W-1:0]      r_pack_count;
    logic                  r_pack_full;

    // ------------------------------------------------------------------
    // Staged register
    // ------------------------------------------------------------------
    logic [PAYLOAD_W-1:0]  r_stg_payload;
    logic                  r_stg_last;
    logic [CNT_W-1:0]      r_stg_count;
    logic                  r_staged_valid;

    // Output register
    logic [NORTH_WIDTH-1:0] r_out;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_emit;
    logic                  w_stg_free;
    logic                  w_load_direct;
    logic                  w_load_from_pack;
    logic [CNT_W-1:0]      w_cnt_plus1;
    logic [DATA_WIDTH-1:0] w_lane_next [LANES];
    logic [PAYLOAD_W-1:0]  w_next_payload;
    logic [PAYLOAD_W-1:0]  w_pack_payload;

    assign din_ready        = !r_pack_full;
    assign w_accept         = din_valid && !r_pack_full;
    assign w_complete       = w_accept && ((r_cnt == LAST_SLOT) || din_last);
    assign w_emit           = r_staged_valid && ap_start;
    // Staged can take a word if empty or if its current word leaves this edge.
    assign w_stg_free       = !r_staged_valid || w_emit;
    // A held pack word never coincides with an accept (din_ready is low).
    assign w_load_from_pack = r_pack_full && w_stg_free;
    assign w_load_direct    = w_complete && w_stg_free;
    assign w_cnt_plus1      = r_cnt + 1'b1;

    // Lane image after this cycle's accept: slots below cnt keep their data,
    // slot cnt takes din, slots above cnt are forced to zero so a short word
    // never carries stale lanes from an earlier word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            always_comb begin
                w_lane_next[gi] = '0;
                if (r_cnt == CNT_W'(gi)) begin
                    w_lane_next[gi] = din;
                end else if (r_cnt > CNT_W'(gi)) begin
                    w_lane_next[gi] = r_lane[gi];
                end
            end

            assign w_next_payload[gi*DATA_WIDTH +: DATA_WIDTH] = w_lane_next[gi];
            assign w_pack_payload[gi*DATA_WIDTH +: DATA_WIDTH] = r_lane[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_lane[gi] <= '0;
                end else if (w_accept) begin
                    r_lane[gi] <= w_lane_next[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pack control: lane counter, completed-word metadata, pack_full
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pack_last  <= 1'b0;
            r_pack_count <= '0;
            r_pack_full  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_complete ? '0 : w_cnt_plus1;
            end
            if (w_complete) begin
                r_pack_last  <= din_last;
                r_pack_count <= w_cnt_plus1;
            end
            if (w_load_from_pack) begin
                r_pack_full <= 1'b0;
            end else if (w_complete && !w_stg_free) begin
                r_pack_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Staged register: loaded either from the pack register or straight
    // from a lane that completes a word this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stg_payload  <= '0;
            r_stg_last     <= 1'b0;
            r_stg_count    <= '0;
            r_staged_valid <= 1'b0;
        end else begin
            if (w_load_from_pack) begin
                r_stg_payload <= w_pack_payload;
                r_stg_last    <= r_pack_last;
                r_stg_count   <= r_pack_count;
            end else if (w_load_direct) begin
                r_stg_payload <= w_next_payload;
                r_stg_last    <= din_last;
                r_stg_count   <= w_cnt_plus1;
            end

            if (w_load_from_pack || w_load_direct) begin
                r_staged_valid <= 1'b1;
            end else if (w_emit) begin
                r_staged_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: a word is presented for exactly one cycle, zero
    // otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_emit) begin
            r_out <= {1'b1, r_stg_last, {PAD_W{1'b0}}, r_stg_count, r_stg_payload};
        end else begin
            r_out <= '0;
        end
    end

    assign out_to_north = r_out;
    assign busy         = (r_cnt != '0) || r_pack_full || r_staged_valid;

endmodule

// File: tb/tb_pe_link_packer.sv
// -----------------------------------------------------------------------------
// Testbench for pe_link_packer. A queue-based model tracks accepted lanes and
// the words they form; a negedge monitor compares out_to_north, din_ready and
// busy against it every cycle. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_pe_link_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         ap_start;
    logic [31:0]  din;
    logic         din_valid;
    logic         din_last;
    logic         din_ready;
    logic [129:0] out_to_north;
    logic         busy;

    pe_link_packer #(
        .NORTH_WIDTH (130),
        .DATA_WIDTH  (32),
        .LANES       (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ap_start     (ap_start),
        .din          (din),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din_ready    (din_ready),
        .out_to_north (out_to_north),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stall_cnt = 0;
    int cyc = 0;

    // Model state
    logic [31:0]  m_part[$];     // lanes of the word being collected
    logic [129:0] m_q[$];        // formed words not yet emitted
    logic [129:0] emitted[$];    // every word seen on the link
    int           emit_cyc[$];   // monitor cycle of each emission
    logic         rec_acc = 1'b0;
    logic         rec_last = 1'b0;
    logic         rec_ap = 1'b0;
    logic [31:0]  rec_din = '0;

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor and model. Inputs change at posedge+1, so the values seen at a
    // negedge are exactly those the following rising edge will act on.
    always @(negedge clk) begin
        logic [129:0] exp_w;
        logic [95:0]  pl;
        cyc++;
        if (reset) begin
            m_part.delete();
            m_q.delete();
            rec_acc = 1'b0;
            rec_ap  = 1'b0;
            chk("rst_out", out_to_north, '0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_ready", din_ready, 1'b1);
        end else begin
            // Any word formed before the last edge must leave at that edge
            // if the link was enabled; otherwise the link carries zero.
            exp_w = '0;
            if (rec_ap && m_q.size() > 0) exp_w = m_q[0];
            chk("out_word", out_to_north, exp_w);
            if (out_to_north[129]) begin
                emitted.push_back(out_to_north);
                emit_cyc.push_back(cyc);
            end
            if (exp_w[129]) void'(m_q.pop_front());

            if (rec_acc) begin
                m_part.push_back(rec_din);
                if (m_part.size() == 3 || rec_last) begin
                    pl = '0;
                    for (int i = 0; i < m_part.size(); i++) pl[32*i +: 32] = m_part[i];
                    m_q.push_back({1'b1, rec_last, 30'b0, 2'(m_part.size()), pl});
                    m_part.delete();
                end
            end

            // Two words of storage: input stalls only when both are in use.
            chk1("ready", din_ready, m_q.size() < 2);
            chk1("busy", busy, (m_part.size() > 0) || (m_q.size() > 0));

            rec_acc  = din_valid && din_ready;
            rec_din  = din;
            rec_last = din_last;
            rec_ap   = ap_start;
        end
    end

    // Offer one lane and hold it until accepted (bounded).
    task automatic send(input logic [31:0] d, input logic l);
        logic rdy;
        int   n;
        n = 0;
        din = d;
        din_last = l;
        din_valid = 1'b1;
        forever begin
            rdy = din_ready;
            @(posedge clk); #1;
            if (rdy) break;
            stall_cnt++;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got ready=0 want ready=1 within 200 cycles");
                break;
            end
        end
        din_valid = 1'b0;
        din_last = 1'b0;
        din = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int sidx;
        logic tog_run;
        logic [129:0] w;

        reset = 1'b1;
        ap_start = 1'b0;
        din_valid = 1'b0;
        din_last = 1'b0;
        din = '0;
        cycles(3);
        chk1("reset_busy", busy, 1'b0);
        chk("reset_out", out_to_north, '0);
        reset = 1'b0;
        ap_start = 1'b1;

        // 1: three-lane frame, one cycle of latency after the last accept
        n0 = emitted.size();
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b1);
        chk1("t1_not_yet", out_to_north[129], 1'b0);
        cycles(1);
        chk("t1_word", out_to_north, {1'b1, 1'b1, 30'b0, 2'd3, 96'h00000033_00000022_00000011});
        cycles(4);
        chk32("t1_count", emitted.size() - n0, 1);

        // 2: single-lane frame
        send(32'h0000ABCD, 1'b1);
        cycles(1);
        chk("t2_word", out_to_north, {1'b1, 1'b1, 30'b0, 2'd1, 64'b0, 32'h0000ABCD});
        cycles(3);

        // 3: link disabled, fill both words, then enable
        ap_start = 1'b0;
        stall_cnt = 0;
        n0 = emitted.size();
        for (int i = 0; i < 6; i++) send(32'h100 + i, 1'b0);
        chk32("t3_no_stall_first6", stall_cnt, 0);
        chk1("t3_ready_low", din_ready, 1'b0);
        cycles(3);
        chk1("t3_ready_still_low", din_ready, 1'b0);
        chk32("t3_no_emit_disabled", emitted.size() - n0, 0);
        ap_start = 1'b1;
        for (int i = 6; i < 9; i++) send(32'h100 + i, 1'b0);
        cycles(6);
        chk32("t3_count", emitted.size() - n0, 3);
        if (emitted.size() - n0 == 3) begin
            chk("t3_first", emitted[n0], {1'b1, 1'b0, 30'b0, 2'd3, 96'h00000102_00000101_00000100});
            chk("t3_third", emitted[n0+2], {1'b1, 1'b0, 30'b0, 2'd3, 96'h00000108_00000107_00000106});
        end

        // 4: continuous 30-lane stream
        stall_cnt = 0;
        n0 = emitted.size();
        for (int i = 0; i < 30; i++) send(32'h200 + i, 1'b0);
        cycles(4);
        chk32("t4_count", emitted.size() - n0, 10);
        chk32("t4_stalls", stall_cnt, 0);
        if (emitted.size() - n0 == 10) begin
            for (int k = 1; k < 10; k++)
                chk32("t4_spacing", emit_cyc[n0+k] - emit_cyc[n0+k-1], 3);
        end

        // 5: reset after two lanes of a word
        n0 = emitted.size();
        send(32'h301, 1'b0);
        send(32'h302, 1'b0);
        reset = 1'b1;
        cycles(1);
        chk1("t5_busy_in_reset", busy, 1'b0);
        reset = 1'b0;
        cycles(3);
        chk1("t5_busy_after", busy, 1'b0);
        chk32("t5_no_emit", emitted.size() - n0, 0);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b0);
        cycles(1);
        chk("t5_word", out_to_north, {1'b1, 1'b0, 30'b0, 2'd3, 96'h000000A3_000000A2_000000A1});
        cycles(3);

        // 6: ap_start toggling every cycle over a long stream
        n0 = emitted.size();
        tog_run = 1'b1;
        fork
            begin
                while (tog_run) begin
                    @(posedge clk); #1;
                    ap_start = ~ap_start;
                end
            end
            begin
                for (int i = 0; i < 20; i++) send(32'h400 + i, (i % 5) == 4);
                tog_run = 1'b0;
            end
        join
        ap_start = 1'b1;
        cycles(10);
        chk32("t6_count", emitted.size() - n0, 8);
        if (emitted.size() - n0 == 8) begin
            chk("t6_second", emitted[n0+1], {1'b1, 1'b1, 30'b0, 2'd2, 32'b0, 32'h00000404, 32'h00000403});
            sidx = 0;
            for (int k = 0; k < 8; k++) begin
                w = emitted[n0+k];
                for (int j = 0; j < int'(w[97:96]); j++) begin
                    chk32("t6_order", int'(w[32*j +: 32]), 32'h400 + sidx);
                    sidx++;
                end
            end
            chk32("t6_lanes", sidx, 20);
        end

        cycles(5);
        chk32("drain_words", m_q.size(), 0);
        chk32("drain_lanes", m_part.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
